// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   ALU_* : 4-bit ALU control codes, also used by the ALU control decoder.
//   ST_*  : FSM state encoding for alu_iterative.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_load       : latch operands, clear acc and count
//   i_run        : perform one iteration this edge
//   i_mcand      : multiplicand
//   i_mplier     : multiplier
//   o_done       : this edge performs the final (WIDTH-th) iteration
//   o_product    : acc value after the current iteration (low WIDTH bits)
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Final iteration is the one that moves count from WIDTH-1 to WIDTH, so the
  // product is taken from the adder output rather than from r_acc.
  assign o_done    = i_run && (r_count == LAST);
  assign o_product = w_acc_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_count  <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU. AND/OR/ADD/SUB in one cycle, MUL as a
// WIDTH-cycle shift-add with ready_o low while it runs.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   valid_i      : request valid
//   aluCtrl_i    : ALU control code (see alu_pkg)
//   data1_i      : operand A / multiplicand
//   data2_i      : operand B / multiplier
//   ready_o      : request can be accepted (low = stall)
//   valid_o      : one-cycle pulse, new result in data_o/zero_o
//   data_o       : registered result
//   zero_o       : registered, result == 0
//
// state   | meaning
// IDLE    | waiting for a request
// MUL     | shift-add iterations running, ready_o low
// DONE    | MUL result presented (valid_o high), accepts a new request
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       aluCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_valid;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_load;
  logic             w_mul_run;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_result;

  assign ready_o    = (r_state != ST_MUL);
  assign w_accept   = valid_i && ready_o;
  assign w_is_mul   = (aluCtrl_i == ALU_MUL);
  assign w_mul_load = w_accept && w_is_mul;
  assign w_mul_run  = (r_state == ST_MUL);

  always_comb begin
    w_result = '0;
    case (aluCtrl_i)
      ALU_AND: w_result = data1_i & data2_i;
      ALU_OR:  w_result = data1_i | data2_i;
      ALU_ADD: w_result = data1_i + data2_i;
      ALU_SUB: w_result = data1_i - data2_i;
      default: w_result = '0;
    endcase
  end

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_mul_load),
    .i_run    (w_mul_run),
    .i_mcand  (data1_i),
    .i_mplier (data2_i),
    .o_done   (w_mul_done),
    .o_product(w_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_MUL: begin
          r_valid <= 1'b0;
          if (w_mul_done) begin
            r_data  <= w_product;
            r_zero  <= (w_product == '0);
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE behave identically on an accept
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= ST_MUL;
            end else begin
              r_data  <= w_result;
              r_zero  <= (w_result == '0);
              r_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign zero_o  = r_zero;

endmodule

// File: tb/tb_alu_iterative.sv
module tb_alu_iterative;
  import alu_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  aluCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        zero_o;

  int n_total;
  int n_bad;

  alu_iterative #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .aluCtrl_i(aluCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .zero_o   (zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    valid_i   = v;
    aluCtrl_i = c;
    data1_i   = a;
    data2_i   = b;
  endtask

  // Drives a MUL at the current negedge and returns at the negedge of the
  // first cycle with ready_o high again, with the number of stalled cycles.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input bit hold_or,
                        output int stall);
    stall = 0;
    drive(1'b1, ALU_MUL, a, b);
    @(negedge clk_i);
    if (hold_or) drive(1'b1, ALU_OR, 32'h0000_000F, 32'h0000_00F0);
    else         drive(1'b0, ALU_AND, 32'h0, 32'h0);
    while (ready_o == 1'b0 && stall < 100) begin
      if (valid_o !== 1'b0) check_val("mul_stall_valid", {31'b0, valid_o}, 32'h0);
      stall++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    int stall;
    int seen;
    n_total = 0;
    n_bad   = 0;
    rst_i   = 1'b1;
    drive(1'b0, ALU_AND, 32'h0, 32'h0);

    // reset
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_data",  data_o,            32'h0);
    check_val("rst_valid", {31'b0, valid_o},  32'h0);
    check_val("rst_zero",  {31'b0, zero_o},   32'h0);
    check_val("rst_ready", {31'b0, ready_o},  32'h1);

    // back-to-back single-cycle ops
    drive(1'b1, ALU_ADD, 32'h0000_0005, 32'h0000_0003);
    @(negedge clk_i);
    check_val("add_data",  data_o,           32'h0000_0008);
    check_val("add_valid", {31'b0, valid_o}, 32'h1);
    check_val("add_zero",  {31'b0, zero_o},  32'h0);
    drive(1'b1, ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_FF00);
    @(negedge clk_i);
    check_val("and_data",  data_o,           32'h00F0_F000);
    check_val("and_valid", {31'b0, valid_o}, 32'h1);
    drive(1'b1, ALU_SUB, 32'h0000_0005, 32'h0000_0005);
    @(negedge clk_i);
    check_val("sub_data",  data_o,           32'h0);
    check_val("sub_zero",  {31'b0, zero_o},  32'h1);
    check_val("sub_valid", {31'b0, valid_o}, 32'h1);
    drive(1'b0, ALU_AND, 32'h0, 32'h0);
    @(negedge clk_i);
    check_val("idle_valid", {31'b0, valid_o}, 32'h0);
    check_val("idle_zero_hold", {31'b0, zero_o}, 32'h1);

    // MUL 7*6 with an OR request held through the stall
    mul_op(32'h7, 32'h6, 1'b1, stall);
    check_val("mul76_stall", stall,            32);
    check_val("mul76_data",  data_o,           32'h0000_002A);
    check_val("mul76_valid", {31'b0, valid_o}, 32'h1);
    check_val("mul76_zero",  {31'b0, zero_o},  32'h0);
    @(negedge clk_i);
    check_val("or_data",  data_o,           32'h0000_00FF);
    check_val("or_valid", {31'b0, valid_o}, 32'h1);
    drive(1'b0, ALU_AND, 32'h0, 32'h0);
    @(negedge clk_i);
    check_val("or_after_valid", {31'b0, valid_o}, 32'h0);
    check_val("or_hold_data",   data_o,           32'h0000_00FF);

    // wrap-around MULs; second one accepted in the DONE cycle of the first
    mul_op(32'hFFFF_FFFF, 32'h3, 1'b0, stall);
    check_val("mulff_stall", stall,            32);
    check_val("mulff_data",  data_o,           32'hFFFF_FFFD);
    check_val("mulff_valid", {31'b0, valid_o}, 32'h1);
    mul_op(32'h8000_0000, 32'h2, 1'b0, stall);
    check_val("mul80_stall", stall,            32);
    check_val("mul80_data",  data_o,           32'h0);
    check_val("mul80_zero",  {31'b0, zero_o},  32'h1);
    check_val("mul80_valid", {31'b0, valid_o}, 32'h1);

    // nonzero result so the reset clear is visible
    drive(1'b1, ALU_ADD, 32'h10, 32'h20);
    @(negedge clk_i);
    check_val("add30_data", data_o, 32'h30);

    // reset at edge E0+10 of a MUL, with an ADD request held during reset
    drive(1'b1, ALU_MUL, 32'h3, 32'h5);
    @(negedge clk_i);
    drive(1'b0, ALU_AND, 32'h0, 32'h0);
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      if (valid_o) seen++;
      @(negedge clk_i);
    end
    rst_i = 1'b1;
    drive(1'b1, ALU_ADD, 32'h1, 32'h1);
    @(negedge clk_i);
    check_val("rmul_data",  data_o,           32'h0);
    check_val("rmul_valid", {31'b0, valid_o}, 32'h0);
    check_val("rmul_ready", {31'b0, ready_o}, 32'h1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("radd_data",  data_o,           32'h2);
    check_val("radd_valid", {31'b0, valid_o}, 32'h1);
    drive(1'b0, ALU_AND, 32'h0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check_val("rmul_no_valid", seen, 0);
    check_val("rmul_hold_data", data_o, 32'h2);

    // unrecognised code
    drive(1'b1, 4'b0101, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk_i);
    check_val("unk_data",  data_o,           32'h0);
    check_val("unk_zero",  {31'b0, zero_o},  32'h1);
    check_val("unk_valid", {31'b0, valid_o}, 32'h1);
    drive(1'b0, ALU_AND, 32'h0, 32'h0);
    @(negedge clk_i);
    check_val("unk_after_valid", {31'b0, valid_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two register operands. AND, OR, ADD and SUB complete in one cycle. MUL runs as an iterative shift-add over WIDTH cycles. While MUL is running, a valid/ready handshake stalls the pipeline.

## Interface
- WIDTH, 32, operand and result width in bits
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  operation request valid this cycle
- aluCtrl_i  in  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 MUL
- data1_i  in  WIDTH  operand A (multiplicand for MUL)
- data2_i  in  WIDTH  operand B (multiplier for MUL)
- ready_o  out  1  block can accept a request; low means the hazard unit must stall
- valid_o  out  1  one-cycle pulse: data_o/zero_o hold a new result
- data_o  out  WIDTH  registered result
- zero_o  out  1  registered, high when the result loaded into data_o is 0

## Operation
- **Accept:** an accept occurs on a rising edge where valid_i && ready_o. valid_i while ready_o=0 is ignored; nothing is queued. Upstream holds its request until ready_o is high.
- **States:** IDLE, MUL, DONE. ready_o = (state != MUL), derived combinationally from state.
- **IDLE/DONE, accept of a non-MUL code:**
  - data_o is loaded with the result.
  - zero_o is loaded with (result == 0).
  - valid_o is asserted the next cycle.
  - Next state is IDLE.
- **IDLE/DONE, accept of MUL:**
  - Latch multiplicand = data1_i, multiplier = data2_i, acc = 0, count = 0.
  - Next state is MUL.
- **IDLE/DONE, no accept:** next state is IDLE. valid_o drops.
- **MUL, each edge:**
  - If multiplier[0] = 1, acc += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, count++.
  - On the edge where count reaches WIDTH:
    - data_o = final acc.
    - zero_o = (final acc == 0).
    - Next state is DONE.
- **DONE:** valid_o = 1 for exactly this one cycle. An accept in DONE is legal and behaves as it does in IDLE.
- **Arithmetic rules:**
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - MUL returns the low WIDTH bits of the product. These bits are identical for signed and unsigned operands.
- **Unrecognised codes** (every code other than the five listed) produce result 0, zero_o = 1, and single-cycle latency.
- **Between results:** data_o and zero_o hold their last values until the next result is loaded.
- **Reset values:**
  - data_o = 0, zero_o = 0, valid_o = 0.
  - State = IDLE, so ready_o = 1 in the cycle after reset.
  - Count and acc are cleared.
- **Reset during MUL:** the operation is aborted, no valid_o is produced, and data_o is cleared to 0.
- **Reset with valid_i high:** reset wins; the request is not accepted.

## Timing
- **Single-cycle ops:** accepted at edge E0, so valid_o and data_o are visible in the cycle after E0 (latency 1).
- **MUL:**
  - Accepted at edge E0.
  - Iterations occur on edges E0+1 … E0+WIDTH.
  - valid_o is high in the cycle after E0+WIDTH, so latency is WIDTH+1 edges.
  - ready_o is low from after E0 through E0+WIDTH (WIDTH cycles of stall).
- **Back-to-back single-cycle ops:** one accepted per cycle; valid_o stays high continuously.
- **MUL followed by another op:** the new op can be accepted in the DONE cycle. Its result follows on the next cycle, so no valid bubble appears.
- **Path constraint:** no combinational path from any input to any output. ready_o depends on state only.

## Structure
- Shared package alu_pkg holds:
  - The ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL). The control decoder uses these same constants.
  - The state encoding (IDLE, MUL, DONE).
- One sub-module, mul_shift_add, holds the multiplicand/multiplier/acc registers and the iteration counter.
  - Inputs: load pulse and operands.
  - Outputs: done and product.
- The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- **Reset:** hold rst_i for 2 cycles, then release. Expect data_o=0, valid_o=0, zero_o=0 and ready_o=1 in the first cycle after release.
- **Back-to-back single-cycle ops:** issue ADD 0x00000005+0x00000003, then AND 0xF0F0F0F0&0x0FF0FF00, then SUB 5-5 on consecutive cycles. Expect 0x00000008, 0x00F0F000, then 0x00000000 with zero_o=1, with valid_o high for 3 consecutive cycles.
- **MUL 7*6:**
  - Expect ready_o low for exactly 32 cycles.
  - Expect data_o=0x0000002A with a valid_o pulse in the cycle after E0+32.
  - valid_i held high with an OR request during the stall must be accepted only in the DONE cycle. Its result follows one cycle later.
- **MUL 0xFFFFFFFF*3:** expect 0xFFFFFFFD. Then MUL 0x80000000*2: expect 0x00000000 with zero_o=1.
- **Reset during MUL:** assert rst_i at edge E0+10 of a MUL. Expect no valid_o ever, data_o=0, and ready_o=1 the next cycle. A following ADD 1+1 returns 2 with latency 1.
- **Unknown code:** request with aluCtrl_i=0101. Expect data_o=0, zero_o=1, valid_o the next cycle.
